// File: rtl/bcd_time_counter.sv
// Time-of-day counter: packed 2-digit BCD seconds/minutes/24h hours, 1 Hz tick,
// front-panel set mode, midnight carry. Optional hourly chime via HOURLY_CHIME_EN.
module bcd_time_counter #(
  parameter logic [7:0] INIT_HOUR = 8'h00,
  parameter logic [7:0] INIT_MIN  = 8'h00
) (
  input  logic       clk,
  input  logic       cr,
  input  logic       en,
  input  logic       tick,
  input  logic       set_mode,
  input  logic       adj_min,
  input  logic       adj_hour,
  output logic [7:0] Second,
  output logic [7:0] Minute,
  output logic [7:0] Hour24,
  output logic       day_carry,
  output logic       chime
);

  logic [7:0] sec_n, min_n, hour_n;
  logic       day_carry_n;

  // Increment a 2-digit BCD value, wrapping to 00 once max_v is reached.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
    if (v == max_v)
      return 8'h00;
    else if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    sec_n       = Second;
    min_n       = Minute;
    hour_n      = Hour24;
    day_carry_n = 1'b0;
    if (set_mode) begin
      // Adjust keys move one field each and never ripple into the next field.
      if (adj_min) begin
        min_n = bcd_inc(Minute, 8'h59);
        sec_n = 8'h00;
      end
      if (adj_hour)
        hour_n = bcd_inc(Hour24, 8'h23);
    end else if (en && tick) begin
      sec_n = bcd_inc(Second, 8'h59);
      if (Second == 8'h59) begin
        min_n = bcd_inc(Minute, 8'h59);
        if (Minute == 8'h59) begin
          hour_n      = bcd_inc(Hour24, 8'h23);
          day_carry_n = (Hour24 == 8'h23);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (cr) begin
      Second    <= 8'h00;
      Minute    <= INIT_MIN;
      Hour24    <= INIT_HOUR;
      day_carry <= 1'b0;
    end else begin
      Second    <= sec_n;
      Minute    <= min_n;
      Hour24    <= hour_n;
      day_carry <= day_carry_n;
    end
  end

`ifdef HOURLY_CHIME_EN
  logic chime_n;

  // Decode the state being loaded this edge so chime lines up with the displayed time.
  always_comb begin
    chime_n = 1'b0;
    if (!set_mode) begin
      if (min_n == 8'h59 && sec_n[7:4] == 4'd5 && !sec_n[0])
        chime_n = 1'b1;
      else if (min_n == 8'h00 && sec_n == 8'h00)
        chime_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (cr)
      chime <= 1'b0;
    else
      chime <= chime_n;
  end
`else
  assign chime = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed-vector bench for bcd_time_counter: stimulus pushes hand-computed
// expectations into a scoreboard queue, a monitor pops and compares each cycle.
module tb_bcd_time_counter;

  logic       clk = 1'b0;
  logic       cr = 1'b0, en = 1'b0, tick = 1'b0, set_mode = 1'b0;
  logic       adj_min = 1'b0, adj_hour = 1'b0;
  logic [7:0] Second, Minute, Hour24;
  logic       day_carry, chime;

  int checks_total = 0;
  int checks_passed = 0;

  typedef struct {
    bit         chk;
    string      name;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic       dc;
    logic       ch;
  } exp_t;

  exp_t sb[$];

  bcd_time_counter #(.INIT_HOUR(8'h12), .INIT_MIN(8'h34)) dut (
    .clk(clk), .cr(cr), .en(en), .tick(tick), .set_mode(set_mode),
    .adj_min(adj_min), .adj_hour(adj_hour),
    .Second(Second), .Minute(Minute), .Hour24(Hour24),
    .day_carry(day_carry), .chime(chime)
  );

  always #5 clk = ~clk;

  // Expected chime for a given resulting time.
  function automatic logic chime_model(input logic c, input logic sm,
                                       input logic [7:0] m, input logic [7:0] s);
`ifdef HOURLY_CHIME_EN
    if (c || sm) return 1'b0;
    if (m == 8'h59 && (s == 8'h50 || s == 8'h52 || s == 8'h54 || s == 8'h56 || s == 8'h58))
      return 1'b1;
    return (m == 8'h00 && s == 8'h00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] req);
    checks_total++;
    if (act === req)
      checks_passed++;
    else
      $display("FAIL %s: got h=%h m=%h s=%h dc=%b ch=%b, expected h=%h m=%h s=%h dc=%b ch=%b",
               name, act[25:18], act[17:10], act[9:2], act[1], act[0],
               req[25:18], req[17:10], req[9:2], req[1], req[0]);
  endtask

  // One clock of stimulus plus the expected state after the next rising edge.
  task automatic step(input logic c, input logic e, input logic t, input logic sm,
                      input logic am, input logic ah, input bit chk, input string nm,
                      input logic [7:0] eh, input logic [7:0] em, input logic [7:0] es,
                      input logic edc);
    exp_t x;
    @(negedge clk);
    cr = c; en = e; tick = t; set_mode = sm; adj_min = am; adj_hour = ah;
    x.chk = chk; x.name = nm; x.hour = eh; x.min = em; x.sec = es; x.dc = edc;
    x.ch = chime_model(c, sm, em, es);
    sb.push_back(x);
  endtask

  task automatic tk(input int n);
    repeat (n) step(0, 1, 1, 0, 0, 0, 0, "", 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic am_n(input int n);
    repeat (n) step(0, 1, 0, 1, 1, 0, 0, "", 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  task automatic ah_n(input int n);
    repeat (n) step(0, 1, 0, 1, 0, 1, 0, "", 8'h00, 8'h00, 8'h00, 1'b0);
  endtask

  // Monitor: one scoreboard entry per clock, sampled just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk)
          check(e.name, {Hour24, Minute, Second, day_carry, chime},
                {e.hour, e.min, e.sec, e.dc, e.ch});
      end
    end
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 1, "reset_init", 8'h12, 8'h34, 8'h00, 1'b0);
    step(0, 1, 0, 0, 0, 0, 1, "hold_no_tick", 8'h12, 8'h34, 8'h00, 1'b0);
    tk(8);
    step(0, 1, 1, 0, 0, 0, 1, "tick_to_09", 8'h12, 8'h34, 8'h09, 1'b0);
    step(0, 1, 1, 0, 0, 0, 1, "sec_units_carry", 8'h12, 8'h34, 8'h10, 1'b0);

    am_n(24);
    step(0, 1, 0, 1, 1, 0, 1, "adj_min_to_59", 8'h12, 8'h59, 8'h00, 1'b0);
    step(0, 1, 0, 1, 1, 0, 1, "adj_min_wrap", 8'h12, 8'h00, 8'h00, 1'b0);
    ah_n(11);
    step(0, 1, 0, 1, 0, 1, 1, "adj_hour_wrap", 8'h00, 8'h00, 8'h00, 1'b0);
    step(0, 1, 0, 0, 0, 0, 1, "set_exit_hold", 8'h00, 8'h00, 8'h00, 1'b0);

    tk(58);
    step(0, 1, 1, 0, 0, 0, 1, "sec_59", 8'h00, 8'h00, 8'h59, 1'b0);
    step(0, 1, 1, 0, 0, 0, 1, "min_carry_60_ticks", 8'h00, 8'h01, 8'h00, 1'b0);

    ah_n(23);
    am_n(58);
    tk(58);
    step(0, 1, 1, 0, 0, 0, 1, "pre_midnight", 8'h23, 8'h59, 8'h59, 1'b0);
    step(0, 1, 1, 0, 0, 0, 1, "midnight_wrap", 8'h00, 8'h00, 8'h00, 1'b1);
    step(0, 1, 0, 0, 0, 0, 1, "day_carry_one_clk", 8'h00, 8'h00, 8'h00, 1'b0);

    ah_n(9);
    am_n(59);
    tk(59);
    step(0, 1, 1, 0, 0, 0, 1, "hour_09_to_10", 8'h10, 8'h00, 8'h00, 1'b0);

    am_n(59);
    tk(29);
    step(0, 1, 1, 0, 0, 0, 1, "at_10_59_30", 8'h10, 8'h59, 8'h30, 1'b0);
    step(0, 1, 1, 1, 0, 0, 1, "set_rise_with_tick", 8'h10, 8'h59, 8'h30, 1'b0);
    step(0, 1, 1, 1, 0, 0, 0, "", 8'h00, 8'h00, 8'h00, 1'b0);
    step(0, 1, 1, 1, 0, 0, 1, "set_ticks_frozen", 8'h10, 8'h59, 8'h30, 1'b0);
    step(0, 1, 0, 1, 1, 0, 1, "adj_min_no_hour_carry", 8'h10, 8'h00, 8'h00, 1'b0);
    ah_n(13);
    step(0, 1, 0, 1, 0, 1, 1, "adj_hour_x14_no_carry", 8'h00, 8'h00, 8'h00, 1'b0);

    tk(3);
    repeat (4) step(0, 0, 1, 0, 0, 0, 0, "", 8'h00, 8'h00, 8'h00, 1'b0);
    step(0, 0, 1, 0, 0, 0, 1, "en_low_5_ticks", 8'h00, 8'h00, 8'h03, 1'b0);
    step(0, 1, 0, 0, 1, 1, 1, "adj_ignored_normal", 8'h00, 8'h00, 8'h03, 1'b0);

    ah_n(5);
    am_n(7);
    tk(3);
    step(0, 1, 0, 1, 1, 1, 1, "adj_both_same_cycle", 8'h06, 8'h08, 8'h00, 1'b0);

    ah_n(1);
    am_n(51);
    tk(49);
    step(0, 1, 1, 0, 0, 0, 1, "chime_07_59_50", 8'h07, 8'h59, 8'h50, 1'b0);
    step(0, 1, 1, 0, 0, 0, 1, "chime_07_59_51", 8'h07, 8'h59, 8'h51, 1'b0);
    tk(7);
    step(0, 1, 1, 0, 0, 0, 1, "chime_07_59_59", 8'h07, 8'h59, 8'h59, 1'b0);
    step(0, 1, 1, 0, 0, 0, 1, "chime_08_00_00", 8'h08, 8'h00, 8'h00, 1'b0);
    step(0, 1, 0, 0, 0, 0, 1, "chime_hold_08_00", 8'h08, 8'h00, 8'h00, 1'b0);

    tk(1);
    step(1, 1, 1, 0, 0, 0, 1, "reset_mid_count", 8'h12, 8'h34, 8'h00, 1'b0);
    am_n(2);
    step(1, 1, 0, 1, 1, 1, 1, "reset_mid_setting", 8'h12, 8'h34, 8'h00, 1'b0);
    step(0, 1, 0, 0, 0, 0, 1, "after_reset_hold", 8'h12, 8'h34, 8'h00, 1'b0);

    @(posedge clk);
    #2;
    check("scoreboard_drained", 26'(sb.size()), 26'd0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
